fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter WAIT_LIMIT, default 16: the number of MEM_READY-low cycles in MEM_REQ that forces FAULT (range 1..255).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16: the width of FETCH_COUNT.
REQ-003 The block SHALL have port CLOCK  in  1  single system clock, all state updates on the rising edge.
REQ-004 The block SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port RUN  in  1  level input: start or continue instruction fetching.
REQ-006 The block SHALL have port HALT  in  1  one-cycle-or-longer request to stop after the current instruction.
REQ-007 The block SHALL have port MEM_READY  in  1  memory has valid data on the bus this cycle.
REQ-008 The block SHALL have port EXEC_DONE  in  1  execute unit has finished the dispatched instruction.
REQ-009 The block SHALL have ports PC_ENABLE, PC_RW, PC_COUNT  out  1 each  bus and count controls for the program-counter register.
REQ-010 The block SHALL have ports MAR_ENABLE, MAR_RW  out  1 each  bus controls for the memory-address register.
REQ-011 The block SHALL have ports IR_ENABLE, IR_RW  out  1 each  bus controls for the instruction register.
REQ-012 The block SHALL have ports MEM_ENABLE, MEM_RW  out  1 each  bus controls for the memory port.
REQ-013 The block SHALL have port EXEC_START  out  1  one-cycle pulse that dispatches the loaded instruction.
REQ-014 The block SHALL have port FAULT  out  1  memory-timeout flag.
REQ-015 The block SHALL have port HALTED  out  1  halted flag.
REQ-016 The block SHALL have port STATE  out  3  current state encoding.
REQ-017 The block SHALL have port FETCH_COUNT  out  CNT_WIDTH  number of completed fetches.

Function
REQ-018 Control-pair convention SHALL be: RW=0 means the register reads from the bus; RW=1 means it drives the bus (when ENABLE=1) or may count.
REQ-019 The block SHALL be a Moore/Mealy FSM with states IDLE=0, PC_TO_MAR=1, MEM_REQ=2, DISPATCH=3, EXEC_WAIT=4, HALT_ST=5, FAULT_ST=6; code 7 SHALL be unreachable and SHALL return to IDLE.
REQ-020 Default outputs in every state SHALL be: all *_ENABLE=0, all *_RW=1, PC_COUNT=0, EXEC_START=0.
REQ-021 In IDLE: HALT=1 SHALL go to HALT_ST (priority over RUN); otherwise RUN=1 SHALL go to PC_TO_MAR; otherwise the block SHALL stay in IDLE.
REQ-022 In PC_TO_MAR (exactly 1 cycle): PC_ENABLE=1, PC_RW=1, MAR_ENABLE=1, MAR_RW=0; the next state SHALL be MEM_REQ, with the wait counter cleared to 0.
REQ-023 In MEM_REQ: MEM_ENABLE=1 and MEM_RW=1 every cycle.
REQ-024 In MEM_REQ with MEM_READY=1, in the same cycle: IR_ENABLE=1, IR_RW=0, PC_COUNT=1 (PC_ENABLE stays 0); FETCH_COUNT SHALL increment modulo 2^CNT_WIDTH; the next state SHALL be DISPATCH.
REQ-025 In MEM_REQ with MEM_READY=0: the 8-bit wait counter SHALL increment; when the incremented value equals WAIT_LIMIT, the next state SHALL be FAULT_ST; otherwise the block SHALL stay in MEM_REQ.
REQ-026 Fetch latency SHALL be: PC_TO_MAR at cycle n, the IR load at cycle n+1+k for k wait cycles, and EXEC_START at cycle n+2+k.
REQ-027 In DISPATCH (exactly 1 cycle): EXEC_START=1; EXEC_DONE SHALL be ignored; the next state SHALL be EXEC_WAIT.
REQ-028 In EXEC_WAIT with EXEC_DONE=1, the next state SHALL be: HALT_ST if the halt latch is set; else PC_TO_MAR if RUN=1; else IDLE.
REQ-029 In EXEC_WAIT with EXEC_DONE=0, the block SHALL stay in EXEC_WAIT.
REQ-030 Halt latch SHALL set on any cycle with HALT=1 in any state, SHALL be cleared only by RESET, and SHALL never abort an in-flight fetch or execute.
REQ-031 HALT_ST and FAULT_ST SHALL be terminal until RESET.
REQ-032 HALTED SHALL equal 1 when the state is HALT_ST; FAULT SHALL equal 1 when the state is FAULT_ST.
REQ-033 Bus safety SHALL be guaranteed: in any cycle, at most one of {PC, MAR, IR, MEM} SHALL have ENABLE=1 with RW=1.
REQ-034 Deasserting RUN mid-fetch SHALL NOT abort the fetch; RUN is sampled only in IDLE and EXEC_WAIT.

Reset
REQ-035 When RESET=1 at a clock edge: state SHALL become IDLE, wait counter=0, halt latch=0, FETCH_COUNT=0; combinational outputs SHALL then take IDLE defaults (enables 0, RW 1, PC_COUNT 0, EXEC_START 0, FAULT 0, HALTED 0, STATE 0).
REQ-036 RESET SHALL override every other input in every state, including mid-MEM_REQ and FAULT_ST.

Verification
REQ-037 Reset, then RUN=1 with MEM_READY=1 and EXEC_DONE on the 2nd EXEC_WAIT cycle -> STATE sequence 0,1,2,3,4,4,1; FETCH_COUNT=1 after the first IR load.
REQ-038 MEM_READY held low 3 cycles, then high -> MEM_REQ lasts 4 cycles, exactly 1 PC_COUNT pulse, EXEC_START one cycle after the IR load.
REQ-039 WAIT_LIMIT=4 with MEM_READY stuck low -> FAULT=1 on the 5th cycle after entering MEM_REQ; it stays 1 until RESET, then STATE=0 and FAULT=0.
REQ-040 HALT pulsed for 1 cycle during MEM_REQ -> the fetch and execute complete, then STATE=5 and HALTED=1; RUN is ignored afterwards.
REQ-041 RUN and HALT both high in IDLE -> next STATE=5, and no enable is ever asserted.
REQ-042 Every cycle of all scenarios -> a bus-safety assertion (REQ-033) holds; FETCH_COUNT preloaded by forcing 2^16-1 fetches wraps to 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: sequences PC -> MAR -> memory -> IR, dispatches the
// instruction to the execute unit, and handles halt requests and memory timeouts.
module fetch_sequencer #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 RUN,
  input  logic                 HALT,
  input  logic                 MEM_READY,
  input  logic                 EXEC_DONE,
  output logic                 PC_ENABLE,
  output logic                 PC_RW,
  output logic                 PC_COUNT,
  output logic                 MAR_ENABLE,
  output logic                 MAR_RW,
  output logic                 IR_ENABLE,
  output logic                 IR_RW,
  output logic                 MEM_ENABLE,
  output logic                 MEM_RW,
  output logic                 EXEC_START,
  output logic                 FAULT,
  output logic                 HALTED,
  output logic [2:0]           STATE,
  output logic [CNT_WIDTH-1:0] FETCH_COUNT
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PC_TO_MAR = 3'd1,
    S_MEM_REQ   = 3'd2,
    S_DISPATCH  = 3'd3,
    S_EXEC_WAIT = 3'd4,
    S_HALT      = 3'd5,
    S_FAULT     = 3'd6,
    S_BAD       = 3'd7
  } state_e;

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  state_e               state_q, state_d;
  logic [7:0]           wait_q, wait_d, wait_inc;
  logic                 halt_q, halt_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    cnt_d      = cnt_q;
    wait_inc   = wait_q + 8'd1;
    // A HALT seen this cycle counts as latched, so a stop request coinciding
    // with EXEC_DONE still stops after the current instruction.
    halt_d     = halt_q | HALT;
    PC_ENABLE  = 1'b0;
    PC_RW      = 1'b1;
    PC_COUNT   = 1'b0;
    MAR_ENABLE = 1'b0;
    MAR_RW     = 1'b1;
    IR_ENABLE  = 1'b0;
    IR_RW      = 1'b1;
    MEM_ENABLE = 1'b0;
    MEM_RW     = 1'b1;
    EXEC_START = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (halt_d) state_d = S_HALT;
        else if (RUN) state_d = S_PC_TO_MAR;
      end
      S_PC_TO_MAR: begin
        PC_ENABLE  = 1'b1;
        MAR_ENABLE = 1'b1;
        MAR_RW     = 1'b0;
        wait_d     = '0;
        state_d    = S_MEM_REQ;
      end
      S_MEM_REQ: begin
        MEM_ENABLE = 1'b1;
        if (MEM_READY) begin
          // IR latches the bus while the PC advances in place (no PC bus drive).
          IR_ENABLE = 1'b1;
          IR_RW     = 1'b0;
          PC_COUNT  = 1'b1;
          cnt_d     = cnt_q + CNT_WIDTH'(1);
          state_d   = S_DISPATCH;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == LIMIT) state_d = S_FAULT;
        end
      end
      S_DISPATCH: begin
        EXEC_START = 1'b1;
        state_d    = S_EXEC_WAIT;
      end
      S_EXEC_WAIT: begin
        if (EXEC_DONE) begin
          if (halt_d) state_d = S_HALT;
          else if (RUN) state_d = S_PC_TO_MAR;
          else state_d = S_IDLE;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  assign FAULT       = (state_q == S_FAULT);
  assign HALTED      = (state_q == S_HALT);
  assign STATE       = state_q;
  assign FETCH_COUNT = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized fetch schedules
// checked against per-state output expectations derived from the fetch timeline.
module tb_fetch_sequencer;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  logic RUN = 1'b0, HALT = 1'b0, MEM_READY = 1'b0, EXEC_DONE = 1'b0;

  logic PC_ENABLE, PC_RW, PC_COUNT, MAR_ENABLE, MAR_RW, IR_ENABLE, IR_RW;
  logic MEM_ENABLE, MEM_RW, EXEC_START, FAULT, HALTED;
  logic [2:0]  STATE;
  logic [15:0] FETCH_COUNT;

  logic w_pc_en, w_pc_rw, w_pc_cnt, w_mar_en, w_mar_rw, w_ir_en, w_ir_rw;
  logic w_mem_en, w_mem_rw, w_exec, w_fault, w_halted;
  logic [2:0] w_state;
  logic [3:0] w_count;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [2:0]  obs_st;
  logic [9:0]  obs_ctl;
  logic [15:0] obs_cnt;
  logic [3:0]  obs_cntw;
  logic        obs_fault, obs_halted;

  // Control vector order: PC_EN PC_RW PC_CNT MAR_EN MAR_RW IR_EN IR_RW MEM_EN MEM_RW EXEC_START
  localparam logic [9:0] C_DEF   = 10'b0100101010;
  localparam logic [9:0] C_P2M   = 10'b1101001010;
  localparam logic [9:0] C_MW    = 10'b0100101110;
  localparam logic [9:0] C_MR    = 10'b0110110110;
  localparam logic [9:0] C_DSP   = 10'b0100101011;
  localparam logic [9:0] EN_MASK = 10'b1001010100;

  fetch_sequencer #(.WAIT_LIMIT(4), .CNT_WIDTH(16)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .RUN(RUN), .HALT(HALT), .MEM_READY(MEM_READY),
    .EXEC_DONE(EXEC_DONE), .PC_ENABLE(PC_ENABLE), .PC_RW(PC_RW), .PC_COUNT(PC_COUNT),
    .MAR_ENABLE(MAR_ENABLE), .MAR_RW(MAR_RW), .IR_ENABLE(IR_ENABLE), .IR_RW(IR_RW),
    .MEM_ENABLE(MEM_ENABLE), .MEM_RW(MEM_RW), .EXEC_START(EXEC_START), .FAULT(FAULT),
    .HALTED(HALTED), .STATE(STATE), .FETCH_COUNT(FETCH_COUNT)
  );

  // Narrow-counter copy on the same stimulus, so the counter wrap is reachable quickly.
  fetch_sequencer #(.WAIT_LIMIT(4), .CNT_WIDTH(4)) dut_w (
    .CLOCK(CLOCK), .RESET(RESET), .RUN(RUN), .HALT(HALT), .MEM_READY(MEM_READY),
    .EXEC_DONE(EXEC_DONE), .PC_ENABLE(w_pc_en), .PC_RW(w_pc_rw), .PC_COUNT(w_pc_cnt),
    .MAR_ENABLE(w_mar_en), .MAR_RW(w_mar_rw), .IR_ENABLE(w_ir_en), .IR_RW(w_ir_rw),
    .MEM_ENABLE(w_mem_en), .MEM_RW(w_mem_rw), .EXEC_START(w_exec), .FAULT(w_fault),
    .HALTED(w_halted), .STATE(w_state), .FETCH_COUNT(w_count)
  );

  always #5 CLOCK = ~CLOCK;

  always @(negedge CLOCK) begin
    if (chk_en) begin
      int n;
      n = int'(PC_ENABLE & PC_RW) + int'(MAR_ENABLE & MAR_RW) +
          int'(IR_ENABLE & IR_RW) + int'(MEM_ENABLE & MEM_RW);
      checks++;
      if (n > 1) begin
        errors++;
        $display("FAIL bus_safety: drivers=%0d allowed<=1 at t=%0t", n, $time);
      end
    end
  end

  task automatic cyc(input logic run, input logic halt, input logic ready, input logic done);
    RUN = run; HALT = halt; MEM_READY = ready; EXEC_DONE = done;
    #2;
    obs_st     = STATE;
    obs_ctl    = {PC_ENABLE, PC_RW, PC_COUNT, MAR_ENABLE, MAR_RW, IR_ENABLE, IR_RW,
                  MEM_ENABLE, MEM_RW, EXEC_START};
    obs_cnt    = FETCH_COUNT;
    obs_cntw   = w_count;
    obs_fault  = FAULT;
    obs_halted = HALTED;
    @(posedge CLOCK); #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_st !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", obs_st); end
    checks++;
    if (obs_ctl !== C_DEF) begin errors++; $display("FAIL reset_ctl: got %b want %b", obs_ctl, C_DEF); end
    checks++;
    if (obs_cnt !== 16'd0 || obs_fault !== 1'b0 || obs_halted !== 1'b0) begin
      errors++; $display("FAIL reset_flags: cnt=%0d fault=%b halted=%b want 0/0/0", obs_cnt, obs_fault, obs_halted);
    end
  endtask

  task automatic test_basic_fetch();
    logic [2:0] want [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd1};
    logic [9:0] wctl [7] = '{C_DEF, C_P2M, C_MR, C_DSP, C_DEF, C_DEF, C_P2M};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 1'b0, 1'b1, (i == 5));
      checks++;
      if (obs_st !== want[i] || obs_ctl !== wctl[i]) begin
        errors++;
        $display("FAIL basic_seq[%0d]: state=%0d ctl=%b want state=%0d ctl=%b", i, obs_st, obs_ctl, want[i], wctl[i]);
      end
      if (i == 3) begin
        checks++;
        if (obs_cnt !== 16'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", obs_cnt); end
      end
    end
  endtask

  task automatic test_wait_states();
    int memreq = 0, pcc = 0;
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, (i == 3), 1'b0);
      if (obs_st == 3'd2) memreq++;
      if (obs_ctl[7]) pcc++;
      checks++;
      if (obs_ctl !== ((i == 3) ? C_MR : C_MW)) begin
        errors++; $display("FAIL wait_ctl[%0d]: got %b want %b", i, obs_ctl, (i == 3) ? C_MR : C_MW);
      end
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (memreq != 4 || pcc != 1) begin
      errors++; $display("FAIL wait_counts: memreq=%0d pc_count=%0d want 4/1", memreq, pcc);
    end
    checks++;
    if (obs_st !== 3'd3 || obs_ctl[0] !== 1'b1) begin
      errors++; $display("FAIL wait_dispatch: state=%0d exec_start=%b want 3/1", obs_st, obs_ctl[0]);
    end
  endtask

  task automatic test_fault();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'($urandom), 1'b0, 1'b0, 1'($urandom));
      checks++;
      if (obs_st !== ((i == 5) ? 3'd6 : 3'd2) || obs_fault !== (i == 5)) begin
        errors++; $display("FAIL fault_entry[%0d]: state=%0d fault=%b want %0d/%b", i, obs_st, obs_fault,
                           (i == 5) ? 6 : 2, (i == 5));
      end
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (obs_st !== 3'd6 || obs_fault !== 1'b1 || (obs_ctl & EN_MASK) !== 10'd0) begin
        errors++; $display("FAIL fault_hold[%0d]: state=%0d fault=%b ctl=%b want 6/1 no enables", i, obs_st, obs_fault, obs_ctl);
      end
    end
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_st !== 3'd0 || obs_fault !== 1'b0) begin
      errors++; $display("FAIL fault_reset: state=%0d fault=%b want 0/0", obs_st, obs_fault);
    end
  endtask

  task automatic test_halt_mid_fetch();
    logic [2:0] want [6] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, (i == 2), (i == 3), (i == 5));
      checks++;
      if (obs_st !== want[i]) begin
        errors++; $display("FAIL halt_seq[%0d]: state=%0d want %0d", i, obs_st, want[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'($urandom), 1'($urandom));
      checks++;
      if (obs_st !== 3'd5 || obs_halted !== 1'b1 || obs_ctl !== C_DEF || obs_cnt !== 16'd1) begin
        errors++; $display("FAIL halt_hold[%0d]: state=%0d halted=%b ctl=%b cnt=%0d want 5/1/%b/1",
                           i, obs_st, obs_halted, obs_ctl, obs_cnt, C_DEF);
      end
    end
  endtask

  task automatic test_run_halt_idle();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, (i == 0), 1'($urandom), 1'($urandom));
      checks++;
      if (obs_st !== ((i == 0) ? 3'd0 : 3'd5) || (obs_ctl & EN_MASK) !== 10'd0) begin
        errors++; $display("FAIL run_halt_idle[%0d]: state=%0d ctl=%b want %0d no enables", i, obs_st, obs_ctl,
                           (i == 0) ? 0 : 5);
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    RESET = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    RESET = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_st !== 3'd0 || obs_cnt !== 16'd0 || obs_ctl !== C_DEF) begin
      errors++; $display("FAIL reset_mid_fetch: state=%0d cnt=%0d ctl=%b want 0/0/%b", obs_st, obs_cnt, obs_ctl, C_DEF);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_st !== 3'd0) begin errors++; $display("FAIL reset_halt_cleared: state=%0d want 0", obs_st); end
  endtask

  // Each fetch is a timeline: optional IDLE cycles, PC_TO_MAR, k wait cycles,
  // the IR-load cycle, DISPATCH, then d+1 EXEC_WAIT cycles ending with EXEC_DONE.
  task automatic test_random_fetches();
    int exp_cnt = 0;
    bit in_idle = 1'b1;
    int k, d, nidle;
    logic r;
    do_reset();
    for (int f = 0; f < 24; f++) begin
      k = $urandom_range(0, 3);
      d = $urandom_range(0, 3);
      if (in_idle) begin
        nidle = $urandom_range(0, 2);
        for (int i = 0; i <= nidle; i++) begin
          cyc((i == nidle), 1'b0, 1'($urandom), 1'($urandom));
          checks++;
          if (obs_st !== 3'd0 || obs_ctl !== C_DEF) begin
            errors++; $display("FAIL rnd_idle[%0d]: state=%0d ctl=%b want 0/%b", f, obs_st, obs_ctl, C_DEF);
          end
        end
      end
      cyc(1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
      checks++;
      if (obs_st !== 3'd1 || obs_ctl !== C_P2M) begin
        errors++; $display("FAIL rnd_p2m[%0d]: state=%0d ctl=%b want 1/%b", f, obs_st, obs_ctl, C_P2M);
      end
      for (int i = 0; i <= k; i++) begin
        cyc(1'($urandom), 1'b0, (i == k), 1'($urandom));
        checks++;
        if (obs_st !== 3'd2 || obs_ctl !== ((i == k) ? C_MR : C_MW)) begin
          errors++; $display("FAIL rnd_mem[%0d.%0d]: state=%0d ctl=%b want 2/%b", f, i, obs_st, obs_ctl,
                             (i == k) ? C_MR : C_MW);
        end
      end
      exp_cnt++;
      cyc(1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
      checks++;
      if (obs_st !== 3'd3 || obs_ctl !== C_DSP) begin
        errors++; $display("FAIL rnd_dispatch[%0d]: state=%0d ctl=%b want 3/%b", f, obs_st, obs_ctl, C_DSP);
      end
      checks++;
      if (obs_cnt !== 16'(exp_cnt) || obs_cntw !== 4'(exp_cnt)) begin
        errors++; $display("FAIL rnd_count[%0d]: cnt=%0d cnt4=%0d want %0d/%0d", f, obs_cnt, obs_cntw,
                           16'(exp_cnt), 4'(exp_cnt));
      end
      for (int i = 0; i <= d; i++) begin
        r = 1'($urandom);
        cyc(r, 1'b0, 1'($urandom), (i == d));
        checks++;
        if (obs_st !== 3'd4 || obs_ctl !== C_DEF) begin
          errors++; $display("FAIL rnd_exec[%0d.%0d]: state=%0d ctl=%b want 4/%b", f, i, obs_st, obs_ctl, C_DEF);
        end
      end
      in_idle = !r;
    end
  endtask

  initial begin
    @(posedge CLOCK); #1;
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_fault();
    test_halt_mid_fetch();
    test_run_halt_idle();
    test_reset_mid_fetch();
    test_random_fetches();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
